// File: rtl/rr_index_arbiter_if.sv
// Request/grant bundle between four requesters and rr_index_arbiter.
// The timeout pulse exists only when RR_ARB_TIMEOUT_EN is defined.
interface rr_index_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       busy;
`ifdef RR_ARB_TIMEOUT_EN
  logic       timeout;
`endif

  modport master (
    input  req,
    input  done,
    output gnt_idx,
    output gnt_vld,
`ifdef RR_ARB_TIMEOUT_EN
    output timeout,
`endif
    output busy
  );

  modport slave (
    output req,
    output done,
    input  gnt_idx,
    input  gnt_vld,
`ifdef RR_ARB_TIMEOUT_EN
    input  timeout,
`endif
    input  busy
  );
endinterface

// File: rtl/rr_index_arbiter.sv
// Four-requester round-robin arbiter with a registered 2-bit grant index.
// Define RR_ARB_TIMEOUT_EN to add the MAX_HOLD forced release and timeout pulse.
module rr_index_arbiter #(
  parameter int MAX_HOLD = 15
) (
  input logic                clk,
  input logic                rst,
  rr_index_arbiter_if.master bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] gnt_idx_q;
  logic       gnt_vld_q;
  logic       pick_vld;
  logic [1:0] pick_idx;
  logic [1:0] cand;
  logic       rel_now;
  logic       hold_hit;

`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  logic       timeout_q;
`endif

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_range
    $error("rr_index_arbiter: MAX_HOLD must be within 1..255");
  end

  // Scan from the highest offset down so the requester closest to ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = ptr;
    cand     = 2'b00;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (bus.req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    hold_hit = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    hold_hit = (hold_cnt == 8'(MAX_HOLD - 1));
`endif
    rel_now = bus.done || !bus.req[gnt_idx_q] || hold_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'b00;
      gnt_idx_q <= 2'b00;
      gnt_vld_q <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt  <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state     <= GRANT;
            gnt_idx_q <= pick_idx;
            gnt_vld_q <= 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt  <= 8'd0;
`endif
          end
        end
        GRANT: begin
`ifdef RR_ARB_TIMEOUT_EN
          hold_cnt <= hold_cnt + 8'd1;
`endif
          // All release causes collapse into one release and one ptr step.
          if (rel_now) begin
            state     <= IDLE;
            gnt_vld_q <= 1'b0;
            ptr       <= gnt_idx_q + 2'd1;
`ifdef RR_ARB_TIMEOUT_EN
            timeout_q <= hold_hit;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt_idx = gnt_idx_q;
  assign bus.gnt_vld = gnt_vld_q;
  assign bus.busy    = gnt_vld_q;
`ifdef RR_ARB_TIMEOUT_EN
  assign bus.timeout = timeout_q;
`endif

endmodule
